fetch_unit: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32 core.
- Owns the PC and issues single-outstanding requests to instruction memory. Presents {instr, pc} to the decode stage, which slices opcode/funct3/funct7 for the control unit.
- Honours decode back-pressure and branch/jump redirects from EX; holds at most one instruction in a skid slot so no returned word is ever lost.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Types and constants shared across the RV32 core. The fetch stage uses the FSM states
// and the IF/ID pipeline pair. Decode and flush logic reuse NOP_INSTR.
package core_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  localparam instr_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_t;

  typedef struct packed {
    logic   valid;
    instr_t instr;
    addr_t  pc;
  } if_id_t;

  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

  function automatic addr_t pc_next(input addr_t a);
    return a + addr_t'(4);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register. It keeps one request outstanding to imem,
// uses a one-word skid slot under decode back-pressure, and handles EX redirects.
//
// state  | meaning
// S_REQ  | issue a request at pc
// S_WAIT | request outstanding; a response may chain a back-to-back request
// S_FULL | IF/ID and skid both occupied, waiting for decode to drain
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);
  import core_pkg::*;

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        pc_req_q, pc_req_d;
  logic         drop_q, drop_d;
  if_id_t       skid_q, skid_d;
  if_id_t       if_id_q, if_id_d;
  logic         req_raw;
  addr_t        pc_inc;
  addr_t        redirect_tgt;
  logic         if_id_free;

  assign pc_inc       = pc_next(pc_q);
  assign redirect_tgt = word_align(redirect_pc);
  assign if_id_free   = !if_id_q.valid || id_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_req_d  = pc_req_q;
    drop_d    = drop_q;
    skid_d    = skid_q;
    if_id_d   = if_id_q;
    req_raw   = 1'b0;
    imem_addr = pc_q;

    if (id_ready) begin
      if_id_d.valid = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        req_raw  = 1'b1;
        pc_req_d = pc_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (if_id_free) begin
            // Chain the next request in the same cycle so latency-1 memory sustains 1 instr/cycle
            if_id_d   = '{valid: 1'b1, instr: imem_rdata, pc: pc_req_q};
            pc_d      = pc_inc;
            pc_req_d  = pc_inc;
            req_raw   = 1'b1;
            imem_addr = pc_inc;
          end else begin
            skid_d  = '{valid: 1'b1, instr: imem_rdata, pc: pc_req_q};
            pc_d    = pc_inc;
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (id_ready) begin
          if_id_d      = skid_q;
          skid_d.valid = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect beats everything else. In S_REQ the old-pc request has already gone out,
    // so the state machine has to wait for that response and discard it.
    if (redirect_valid) begin
      if_id_d.valid = 1'b0;
      skid_d.valid  = 1'b0;
      pc_d          = redirect_tgt;
      case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
          drop_d  = 1'b1;
        end
        S_WAIT: begin
          req_raw   = 1'b0;
          imem_addr = pc_q;
          if (imem_rvalid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      pc_req_q <= RESET_PC;
      drop_q   <= 1'b0;
      skid_q   <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
      if_id_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_req_q <= pc_req_d;
      drop_q   <= drop_d;
      skid_q   <= skid_d;
      if_id_q  <= if_id_d;
    end
  end

  assign imem_req    = req_raw & rst_n;
  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.valid ? if_id_q.instr : NOP_INSTR;
  assign if_id_pc    = if_id_q.pc;

  // The skid slot is occupied exactly while in S_FULL, and only ever behind a held IF/ID word
  a_skid_state : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_FULL) == skid_q.valid);
  a_skid_order : assert property (@(posedge clk) disable iff (!rst_n)
    skid_q.valid |-> if_id_q.valid);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table followed by random traffic. A sequential-stream
// reference model and an imem model with per-request latency drive and check the DUT.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          due = 0;
  int          handshakes = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_dec = RST_PC;
  logic        hold = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        chk_v;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rp,
                     input int l, input logic cv, input logic ev, input logic [31:0] ep,
                     input logic er, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.redir = rd; v.rpc = rp; v.lat = l;
    v.chk_v = cv; v.e_valid = ev; v.e_pc = ep; v.e_req = er; v.e_addr = ea;
    vq.push_back(v);
  endtask

  // One cycle: drive inputs and memory response at negedge, then sample and check against the model.
  // The model checks that the fetch and decode streams are sequential from the reset pc or the last
  // redirect target, that only one request is outstanding, and that IF/ID holds while decode stalls.
  task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rp);
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    rst_n = r;
    id_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rp;
    if (pend && due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = paddr ^ KEY;
      pend = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    tgt = {rp[31:2], 2'b00};
    if (!r) begin
      check("req_in_reset", {31'b0, imem_req}, 32'd0);
      exp_fetch = RST_PC;
      exp_dec = RST_PC;
      pend = 1'b0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", {31'b0, if_id_valid}, 32'd1);
        check("stall_pc", if_id_pc, hold_pc);
        check("stall_instr", if_id_instr, hold_instr);
      end
      if (imem_req) begin
        check("single_outstanding", {31'b0, pend}, 32'd0);
        check("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        pend = 1'b1;
        paddr = imem_addr;
        due = cyc + lat;
      end
      if (rd) exp_fetch = tgt;
      if (!if_id_valid) begin
        check("nop_when_invalid", if_id_instr, NOP_INSTR);
      end else if (rdy && !rd) begin
        check("decode_pc", if_id_pc, exp_dec);
        check("decode_instr", if_id_instr, exp_dec ^ KEY);
        exp_dec = exp_dec + 32'd4;
        handshakes++;
      end
      if (rd) exp_dec = tgt;
      hold = if_id_valid && !rdy && !rd;
      hold_pc = if_id_pc;
      hold_instr = if_id_instr;
    end
  endtask

  initial begin
    int hs_base;
    // Directed scenario: streaming, a 5-cycle stall with skid, redirect with a dropped response,
    // redirect coincident with rvalid, redirect from S_FULL, pc wrap, then reset mid-request.
    //  rst rdy rd rpc           lat cv ev  e_pc          er  e_addr
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h100);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h104);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'h100,      1, 32'h108);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 32'h0,      1, 1, 1, 32'h104,      0, 32'h0);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'h104,      0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 1, 32'h108,      1, 32'h10C);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 1, 32'h200,      3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        1, 32'h200);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        1, 32'h204);
    add(1, 1, 0, 32'h0,        3, 1, 1, 32'h200,      0, 32'h0);
    add(1, 1, 0, 32'h0,        3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 1, 32'h302,      3, 1, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h300);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h304);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'h300,      1, 32'h308);
    add(1, 0, 0, 32'h0,        1, 1, 1, 32'h304,      0, 32'h0);
    add(1, 0, 1, 32'hFFFF_FFF8, 1, 1, 1, 32'h304,     0, 32'h0);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'hFFFF_FFF8);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFF8, 1, 32'h0);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 1, 32'h4);
    add(1, 1, 0, 32'h0,        1, 1, 1, 32'h0,        1, 32'h8);
    add(0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0);
    add(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h100);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_valid", {31'b0, if_id_valid}, 32'd0);
    check("reset_instr", if_id_instr, NOP_INSTR);
    check("reset_pc", if_id_pc, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      lat = vq[i].lat;
      step(vq[i].rst, vq[i].rdy, vq[i].redir, vq[i].rpc);
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vq[i].e_req});
      if (vq[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
      if (vq[i].chk_v) begin
        check($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vq[i].e_valid});
        if (vq[i].e_valid) begin
          check($sformatf("v%0d_pc", i), if_id_pc, vq[i].e_pc);
          check($sformatf("v%0d_instr", i), if_id_instr, vq[i].e_pc ^ KEY);
        end
      end
    end

    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("post_reset_valid", {31'b0, if_id_valid}, 32'd0);
    check("post_reset_pc", if_id_pc, 32'h0);
    check("post_reset_addr", imem_addr, 32'h104);

    // Random traffic: stalls, redirects to arbitrary (possibly misaligned) targets, occasional reset.
    hs_base = handshakes;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom);
    end
    check("random_progress", {31'b0, (handshakes - hs_base) >= 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
